tone_gen: RTL and testbench

TONE_GEN -- requirements
Module: tone_gen

---
 rtl/tone_gen.sv | 134 +++++++++++++
 tb/tb_tone_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Square-wave tone generator. A beat_tick latches a note code. Pitch codes get a
// silent articulation gap, then a square wave at the note's pitch. Rest codes
// keep the speaker silent until the next tick.
module tone_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int GAP_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beat_tick,
    input  logic [4:0] note_code,
    output logic       spk,
    output logic [4:0] note_q,
    output logic       sounding,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    // Half-period table indexed by note code. Only entries 1..21 are meaningful.
    typedef logic [31:0][23:0] hp_tab_t;

    // Builds the half-period table once, at elaboration time.
    function automatic hp_tab_t build_hp_tab();
        hp_tab_t tab;
        int      base;
        int      mult;
        tab = '0;
        for (int c = 1; c <= 21; c++) begin
            case ((c - 1) % 7)
                0:       base = 262;
                1:       base = 294;
                2:       base = 330;
                3:       base = 349;
                4:       base = 392;
                5:       base = 440;
                default: base = 494;
            endcase
            mult   = (c <= 7) ? 1 : ((c <= 14) ? 2 : 4);
            tab[c] = 24'(CLK_HZ / (2 * base * mult));
        end
        return tab;
    endfunction

    localparam hp_tab_t     HP_TAB   = build_hp_tab();
    localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] gap_cnt_q, gap_cnt_d;
    logic [23:0] hp_cnt_q, hp_cnt_d;
    logic        spk_q, spk_d;
    logic [4:0]  note_d;
    logic [23:0] hp_last;
    logic        is_pitch;

    // Decode the incoming code and the terminal count for the latched note.
    always_comb begin
        is_pitch = (note_code != 5'd0) && (note_code <= 5'd21);
        hp_last  = HP_TAB[note_q] - 24'd1;
    end

    // Next-state logic. A tick overrides gap expiry and half-period wrap.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        hp_cnt_d  = hp_cnt_q;
        spk_d     = spk_q;
        note_d    = note_q;
        if (beat_tick) begin
            note_d    = note_code;
            gap_cnt_d = 20'd0;
            hp_cnt_d  = 24'd0;
            spk_d     = 1'b0;
            state_d   = is_pitch ? S_GAP : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    spk_d = 1'b0;
                end
                S_GAP: begin
                    spk_d = 1'b0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = S_PLAY;
                        gap_cnt_d = 20'd0;
                        hp_cnt_d  = 24'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 20'd1;
                    end
                end
                S_PLAY: begin
                    if (hp_cnt_q == hp_last) begin
                        hp_cnt_d = 24'd0;
                        spk_d    = ~spk_q;
                    end else begin
                        hp_cnt_d = hp_cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    spk_d   = 1'b0;
                end
            endcase
        end
    end

    // State and counter registers. Reset wins over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= 20'd0;
            hp_cnt_q  <= 24'd0;
            spk_q     <= 1'b0;
            note_q    <= 5'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            spk_q     <= spk_d;
            note_q    <= note_d;
        end
    end

    // Outputs. The speaker is gated by PLAY so it cannot be high while silent.
    always_comb begin
        spk       = spk_q & (state_q == S_PLAY);
        sounding  = (state_q == S_PLAY);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen. A cycle-level reference model tracks the
// time since the last tick and derives the expected speaker waveform from it.
module tb_tone_gen;

    localparam int CLK_HZ = 1048000;
    localparam int GAP    = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beat_tick = 1'b0;
    logic [4:0] note_code = 5'd0;
    logic       spk;
    logic [4:0] note_q;
    logic       sounding;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    tone_gen #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .beat_tick (beat_tick),
        .note_code (note_code),
        .spk       (spk),
        .note_q    (note_q),
        .sounding  (sounding),
        .state_dbg (state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    bit         m_active = 1'b0;
    int         m_el = 0;
    int         m_hp = 1;
    logic [4:0] m_note = 5'd0;
    logic [4:0] exp_q[$];

    // Half-period from the pitch table: three octaves of the C-major scale.
    function automatic int hp_model(input int code);
        int base[7] = '{262, 294, 330, 349, 392, 440, 494};
        int oct;
        oct = (code - 1) / 7;
        return CLK_HZ / (2 * (base[(code - 1) % 7] << oct));
    endfunction

    function automatic bit exp_snd();
        return m_active && (m_el >= GAP);
    endfunction

    // After the gap, spk is high in every odd-numbered half-period.
    function automatic bit exp_spk();
        if (!exp_snd()) return 1'b0;
        return (((m_el - GAP) / m_hp) % 2) == 1;
    endfunction

    // ---------------- driver ----------------
    // Applies inputs for one cycle, advances the model at the edge, and
    // returns at the following falling edge so outputs can be sampled.
    task automatic advance(input bit rst, input bit tk, input logic [4:0] code);
        reset     = rst;
        beat_tick = tk;
        note_code = tk ? code : 5'($urandom_range(0, 31));
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_note   = 5'd0;
            m_el     = 0;
        end else if (tk) begin
            m_note   = code;
            m_active = (code >= 5'd1) && (code <= 5'd21);
            m_el     = 0;
            if (m_active) m_hp = hp_model(int'(code));
        end else begin
            m_el++;
        end
        @(negedge clk);
        reset     = 1'b0;
        beat_tick = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        advance(1'b1, 1'b0, 5'd0);
        n_cmp++;
        if ({spk, sounding, note_q} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_first: spk/snd/note=%b/%b/%0d want 0/0/0", spk, sounding, note_q);
        end
        advance(1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 40; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== 7'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: spk/snd/note=%b/%b/%0d want 0/0/0", i, spk, sounding, note_q);
            end
        end
    endtask

    task automatic test_a4();
        int snd_at = -1;
        int rises[$];
        bit prev = 1'b0;
        advance(1'b0, 1'b1, 5'd6);
        n_cmp++;
        if (note_q !== 5'd6 || sounding !== 1'b0) begin
            n_err++;
            $display("FAIL a4_latch: note/snd=%0d/%b want 6/0", note_q, sounding);
        end
        for (int i = 1; i <= GAP + 1190 + 2380 + 10; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== {exp_spk(), exp_snd(), m_note}) begin
                n_err++;
                $display("FAIL a4_wave cyc %0d: spk/snd/note=%b/%b/%0d want %b/%b/%0d",
                         i, spk, sounding, note_q, exp_spk(), exp_snd(), m_note);
            end
            if (sounding === 1'b1 && snd_at < 0) snd_at = i;
            if (spk === 1'b1 && !prev) rises.push_back(i);
            prev = (spk === 1'b1);
        end
        n_cmp++;
        if (snd_at != 4) begin
            n_err++;
            $display("FAIL a4_sounding_delay: got %0d want 4", snd_at);
        end
        n_cmp++;
        if (rises.size() < 2) begin
            n_err++;
            $display("FAIL a4_rise_count: got %0d want >=2", rises.size());
        end else begin
            if (rises[0] != 4 + 1190) begin
                n_err++;
                $display("FAIL a4_first_rise: got %0d want %0d", rises[0], 4 + 1190);
            end
            n_cmp++;
            if (rises[1] - rises[0] != 2380) begin
                n_err++;
                $display("FAIL a4_period: got %0d want 2380", rises[1] - rises[0]);
            end
        end
    endtask

    task automatic test_rest_cut();
        advance(1'b0, 1'b1, 5'd15);
        for (int i = 1; i <= GAP + 1000 + 123; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== {exp_spk(), exp_snd(), m_note}) begin
                n_err++;
                $display("FAIL rest_cut_wave cyc %0d: spk/snd/note=%b/%b/%0d want %b/%b/%0d",
                         i, spk, sounding, note_q, exp_spk(), exp_snd(), m_note);
            end
        end
        advance(1'b0, 1'b1, 5'd0);
        n_cmp++;
        if ({spk, sounding, note_q} !== 7'd0) begin
            n_err++;
            $display("FAIL rest_cut_stop: spk/snd/note=%b/%b/%0d want 0/0/0", spk, sounding, note_q);
        end
        for (int i = 0; i < 20; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== 7'd0) begin
                n_err++;
                $display("FAIL rest_cut_hold cyc %0d: spk/snd/note=%b/%b/%0d want 0/0/0", i, spk, sounding, note_q);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            int  first_rise = -1;
            bit  prev = 1'b0;
            advance(1'b0, 1'b1, 5'd1);
            n_cmp++;
            if (spk !== 1'b0 || sounding !== 1'b0 || note_q !== 5'd1) begin
                n_err++;
                $display("FAIL b2b_tick %0d: spk/snd/note=%b/%b/%0d want 0/0/1", k, spk, sounding, note_q);
            end
            for (int i = 1; i < 10000; i++) begin
                advance(1'b0, 1'b0, 5'd0);
                n_cmp++;
                if ({spk, sounding, note_q} !== {exp_spk(), exp_snd(), m_note}) begin
                    n_err++;
                    $display("FAIL b2b_wave tick %0d cyc %0d: spk/snd/note=%b/%b/%0d want %b/%b/%0d",
                             k, i, spk, sounding, note_q, exp_spk(), exp_snd(), m_note);
                end
                if (spk === 1'b1 && !prev && first_rise < 0) first_rise = i;
                prev = (spk === 1'b1);
            end
            n_cmp++;
            if (first_rise != GAP + 2000) begin
                n_err++;
                $display("FAIL b2b_first_rise tick %0d: got %0d want %0d", k, first_rise, GAP + 2000);
            end
        end
    endtask

    task automatic test_invalid_code();
        advance(1'b0, 1'b1, 5'd25);
        n_cmp++;
        if (note_q !== 5'd25 || sounding !== 1'b0 || spk !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_latch: spk/snd/note=%b/%b/%0d want 0/0/25", spk, sounding, note_q);
        end
        for (int i = 0; i < 30; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== {1'b0, 1'b0, 5'd25}) begin
                n_err++;
                $display("FAIL invalid_hold cyc %0d: spk/snd/note=%b/%b/%0d want 0/0/25", i, spk, sounding, note_q);
            end
        end
    endtask

    task automatic test_reset_priority();
        advance(1'b1, 1'b1, 5'd3);
        n_cmp++;
        if (note_q !== 5'd0 || sounding !== 1'b0 || spk !== 1'b0) begin
            n_err++;
            $display("FAIL rst_tick_same: spk/snd/note=%b/%b/%0d want 0/0/0", spk, sounding, note_q);
        end
        for (int i = 0; i < 20; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== 7'd0) begin
                n_err++;
                $display("FAIL rst_tick_idle cyc %0d: spk/snd/note=%b/%b/%0d want 0/0/0", i, spk, sounding, note_q);
            end
        end
        advance(1'b0, 1'b1, 5'd3);
        for (int i = 1; i <= GAP + 1587 + 50; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== {exp_spk(), exp_snd(), m_note}) begin
                n_err++;
                $display("FAIL rst_play_wave cyc %0d: spk/snd/note=%b/%b/%0d want %b/%b/%0d",
                         i, spk, sounding, note_q, exp_spk(), exp_snd(), m_note);
            end
        end
        advance(1'b1, 1'b0, 5'd0);
        n_cmp++;
        if ({spk, sounding, note_q} !== 7'd0) begin
            n_err++;
            $display("FAIL mid_play_reset: spk/snd/note=%b/%b/%0d want 0/0/0", spk, sounding, note_q);
        end
        for (int i = 0; i < 3000; i++) begin
            advance(1'b0, 1'b0, 5'd0);
            n_cmp++;
            if ({spk, sounding, note_q} !== 7'd0) begin
                n_err++;
                $display("FAIL post_reset_idle cyc %0d: spk/snd/note=%b/%b/%0d want 0/0/0", i, spk, sounding, note_q);
            end
        end
    endtask

    // Random song: random codes, random beat lengths (some shorter than the
    // gap), occasional resets. note_q is scoreboarded through exp_q.
    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [4:0] code;
            int         len;
            bit         do_rst;
            logic [4:0] want;
            code   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(8, 21));
            len    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(100, 1200);
            do_rst = ($urandom_range(0, 9) == 0);
            exp_q.push_back(do_rst ? 5'd0 : code);
            advance(do_rst, 1'b1, code);
            want = exp_q.pop_front();
            n_cmp++;
            if (note_q !== want) begin
                n_err++;
                $display("FAIL rand_note ev %0d: got %0d want %0d", n, note_q, want);
            end
            for (int i = 1; i < len; i++) begin
                advance(1'b0, 1'b0, 5'd0);
                n_cmp++;
                if ({spk, sounding, note_q} !== {exp_spk(), exp_snd(), m_note}) begin
                    n_err++;
                    $display("FAIL rand_wave ev %0d cyc %0d: spk/snd/note=%b/%b/%0d want %b/%b/%0d",
                             n, i, spk, sounding, note_q, exp_spk(), exp_snd(), m_note);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_a4();
        test_rest_cut();
        test_back_to_back();
        test_invalid_code();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Time limit in case the sequence never completes.
    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
